// File: rtl/cdf_pkg.sv
// Shared definitions for the CDF pipeline: word format, tag placement and entry type.
// Both the store (writeback) and fetch ends import this so the memory word layout agrees.
package cdf_pkg;

    localparam int DATA_W      = 20;
    localparam int ADDR_W      = 16;
    localparam int BUS_W       = 128;
    localparam int NUM_ENTRIES = 256;
    localparam int CNT_W       = 9;

    localparam logic [15:0]       TAG       = 16'hAAAA;
    localparam int                TAG_LSB   = 20;
    localparam int                TAG_MSB   = 35;
    localparam logic [ADDR_W-1:0] BASE_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] address;
    } entry_t;

    // Tagged memory word: data in the low bits, validity tag above it, rest zero.
    function automatic logic [BUS_W-1:0] format_word(input logic [DATA_W-1:0] data);
        logic [BUS_W-1:0] word;
        word                  = '0;
        word[DATA_W-1:0]      = data;
        word[TAG_MSB:TAG_LSB] = TAG;
        return word;
    endfunction

endpackage

// File: rtl/cdf_store_fifo.sv
// Two-entry synchronous FIFO of {data, address} entries between the input and write ports.
// Push is ignored when full and pop when empty; flush empties it in one cycle.
module cdf_store_fifo
    import cdf_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t     mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       do_push_s;
    logic       do_pop_s;

    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Entry storage; cleared on reset so the head reads zero before any push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
            if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cdf_store.sv
// Writeback end of the CDF pipeline: buffers {value, address} beats and writes tagged words.
// Optional address range check enabled by defining CDF_STORE_ADDR_CHECK_EN.
module cdf_store
    import cdf_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_address,
    output logic              in_ready,
    output logic [BUS_W-1:0]  write_bus,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    input  logic              write_ready,
    output logic              done,
    output logic [CNT_W-1:0]  written_count,
    output logic              addr_err
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] accepted_count_r;
    logic [CNT_W-1:0] written_count_r;
    entry_t           head_s;
    entry_t           push_entry_s;
    logic             full_s;
    logic             empty_s;
    logic             in_fire_s;
    logic             write_fire_s;
    logic             push_s;
    logic             run_entry_s;
    logic             abort_s;
    logic             flush_s;
    logic             in_range_s;

    assign in_ready      = (state_r == RUN) && !full_s && (accepted_count_r < CNT_W'(NUM_ENTRIES));
    assign write_enable  = (state_r == RUN) && !empty_s;
    assign in_fire_s     = in_valid && in_ready;
    assign write_fire_s  = write_enable && write_ready;
    // Gate the head so an idle port shows zeros rather than a stale tagged word.
    assign write_bus     = write_enable ? format_word(head_s.data) : {BUS_W{1'b0}};
    assign write_address = write_enable ? head_s.address : {ADDR_W{1'b0}};
    assign done          = (state_r == DONE);
    assign written_count = written_count_r;

    assign run_entry_s   = (state_r == IDLE) && start;
    assign abort_s       = (state_r == RUN) && !start;
    assign flush_s       = run_entry_s || abort_s;
    assign push_s        = in_fire_s && in_range_s;
    assign push_entry_s  = '{data: in_data, address: in_address};

`ifdef CDF_STORE_ADDR_CHECK_EN
    logic addr_err_r;

    assign in_range_s = (in_address >= BASE_ADDR) &&
                        ({1'b0, in_address} <= ({1'b0, BASE_ADDR} + 17'(NUM_ENTRIES - 1)));
    assign addr_err   = addr_err_r;

    // Sticky out-of-range flag, cleared at the start of each run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_err_r <= 1'b0;
        end else if (run_entry_s) begin
            addr_err_r <= 1'b0;
        end else if (in_fire_s && !in_range_s) begin
            addr_err_r <= 1'b1;
        end
    end
`else
    assign in_range_s = 1'b1;
    assign addr_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort takes priority over completion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (!start)
                    state_next_s = IDLE;
                else if (write_fire_s && (written_count_r == CNT_W'(NUM_ENTRIES - 1)))
                    state_next_s = DONE;
                else
                    state_next_s = RUN;
            end
            DONE: begin
                if (!start) state_next_s = IDLE;
                else        state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Accepted and written counters, zeroed on run entry and on abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            accepted_count_r <= '0;
            written_count_r  <= '0;
        end else if (flush_s) begin
            accepted_count_r <= '0;
            written_count_r  <= '0;
        end else begin
            if (in_fire_s)    accepted_count_r <= accepted_count_r + 9'd1;
            if (write_fire_s) written_count_r  <= written_count_r + 9'd1;
        end
    end

    cdf_store_fifo u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush_s),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (write_fire_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s)
    );

endmodule

// File: tb/tb_cdf_store.sv
// Self-checking bench for cdf_store: scoreboard of accepted beats against completed writes,
// plus per-cycle handshake/counter model checks in scenario tasks.
module tb_cdf_store;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         in_valid;
    logic [19:0]  in_data;
    logic [15:0]  in_address;
    logic         in_ready;
    logic [127:0] write_bus;
    logic [15:0]  write_address;
    logic         write_enable;
    logic         write_ready;
    logic         done;
    logic [8:0]   written_count;
    logic         addr_err;

    int total;
    int bad;
    int sent;
    int wr;

    logic [35:0]  sb_q [$];
    logic [35:0]  mon_entry;
    logic [127:0] mon_word;

    cdf_store dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_address    (in_address),
        .in_ready      (in_ready),
        .write_bus     (write_bus),
        .write_address (write_address),
        .write_enable  (write_enable),
        .write_ready   (write_ready),
        .done          (done),
        .written_count (written_count),
        .addr_err      (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: push accepted beats, pop and compare on each completed write.
    always @(negedge clock) begin
        if (reset_n && in_valid && in_ready) begin
`ifdef CDF_STORE_ADDR_CHECK_EN
            if (in_address <= 16'h00FF) sb_q.push_back({in_address, in_data});
`else
            sb_q.push_back({in_address, in_data});
`endif
        end
        if (reset_n && write_enable && write_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_write: got addr=%h bus=%h, required no write", write_address, write_bus);
            end else begin
                mon_entry = sb_q.pop_front();
                mon_word = '0;
                mon_word[19:0]  = mon_entry[19:0];
                mon_word[35:20] = 16'hAAAA;
                if (write_bus !== mon_word || write_address !== mon_entry[35:20]) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%h bus=%h, required addr=%h bus=%h",
                             write_address, write_bus, mon_entry[35:20], mon_word);
                end
            end
        end
    end

    task automatic begin_run;
        start = 1'b1;
        @(posedge clock); #1;
        sent = 0;
        wr = 0;
        sb_q.delete();
    endtask

    task automatic end_run;
        @(posedge clock); #1;
        start = 1'b0;
        in_valid = 1'b0;
        write_ready = 1'b0;
        @(posedge clock); #1;
        total++;
        if (done !== 1'b0 || write_enable !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL end_run_idle: got done=%b we=%b rdy=%b, required 0 0 0", done, write_enable, in_ready);
        end
        sb_q.delete();
        write_ready = 1'b1;
    endtask

    // Offer sequential beats (data=address=index) and check handshake/counters every cycle.
    task automatic stream(input int n_beats, input int stop_sent, input int stop_wr,
                          input int stall_at, input int stall_len, input int budget);
        int cyc;
        int wr_before;
        int stall_left;
        bit stall_armed;
        bit holding;
        bit exp_rdy;
        bit exp_we;
        logic [127:0] held_bus;
        logic [15:0]  held_addr;
        cyc = 0;
        stall_left = 0;
        stall_armed = (stall_at >= 0);
        holding = 1'b0;
        held_bus = '0;
        held_addr = '0;
        forever begin
            @(posedge clock); #1;
            if (stall_armed && sent >= stall_at) begin
                stall_left = stall_len;
                stall_armed = 1'b0;
            end
            in_valid    = (sent < n_beats);
            in_data     = 20'(sent);
            in_address  = 16'(sent);
            write_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clock);
            wr_before = wr;
            exp_rdy = (wr < 256) && (sent - wr < 2) && (sent < 256);
            exp_we  = (wr < 256) && (sent - wr > 0);
            total += 4;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL in_ready: got %b, required %b (sent=%0d wr=%0d)", in_ready, exp_rdy, sent, wr);
            end
            if (write_enable !== exp_we) begin
                bad++;
                $display("FAIL write_enable: got %b, required %b (sent=%0d wr=%0d)", write_enable, exp_we, sent, wr);
            end
            if (written_count !== 9'(wr)) begin
                bad++;
                $display("FAIL written_count: got %0d, required %0d", written_count, wr);
            end
            if (done !== (wr == 256)) begin
                bad++;
                $display("FAIL done: got %b, required %b", done, (wr == 256));
            end
            if (write_enable && !write_ready) begin
                if (holding) begin
                    total++;
                    if (write_bus !== held_bus || write_address !== held_addr) begin
                        bad++;
                        $display("FAIL stall_hold: got addr=%h bus=%h, required addr=%h bus=%h",
                                 write_address, write_bus, held_addr, held_bus);
                    end
                end else begin
                    held_bus  = write_bus;
                    held_addr = write_address;
                    holding   = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            if (write_enable && write_ready) wr++;
            cyc++;
            if ((stop_sent >= 0 && sent >= stop_sent) || (stop_wr >= 0 && wr_before >= stop_wr)) break;
            if (cyc >= budget) begin
                total++;
                bad++;
                $display("FAIL stream_timeout: got sent=%0d wr=%0d after %0d cycles, required stop", sent, wr, cyc);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (in_ready !== 1'b0 || write_enable !== 1'b0 || write_bus !== 128'd0 || write_address !== 16'd0 ||
            done !== 1'b0 || written_count !== 9'd0 || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b we=%b bus=%h addr=%h done=%b cnt=%0d err=%b, required all 0",
                     in_ready, write_enable, write_bus, write_address, done, written_count, addr_err);
        end
    endtask

    task automatic test_full_run;
        begin_run();
        stream(256, -1, 256, -1, 0, 2000);
        total++;
        if (sb_q.size() != 0 || wr != 256) begin
            bad++;
            $display("FAIL full_run_count: got writes=%0d pending=%0d, required 256 0", wr, sb_q.size());
        end
    endtask

    task automatic test_after_done;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            in_valid   = 1'b1;
            in_data    = 20'(i + 300);
            in_address = 16'(i);
            @(negedge clock);
            total++;
            if (in_ready !== 1'b0 || write_enable !== 1'b0 || written_count !== 9'd256 || done !== 1'b1) begin
                bad++;
                $display("FAIL after_done: got rdy=%b we=%b cnt=%0d done=%b, required 0 0 256 1",
                         in_ready, write_enable, written_count, done);
            end
        end
        in_valid = 1'b0;
        end_run();
    endtask

    task automatic test_backpressure;
        begin_run();
        stream(256, -1, 256, 3, 5, 2000);
        total++;
        if (sb_q.size() != 0 || wr != 256) begin
            bad++;
            $display("FAIL backpressure_count: got writes=%0d pending=%0d, required 256 0", wr, sb_q.size());
        end
        end_run();
    endtask

    task automatic test_abort;
        begin_run();
        stream(256, 100, -1, -1, 0, 1000);
        @(posedge clock); #1;
        start = 1'b0;
        in_valid = 1'b0;
        write_ready = 1'b0;
        @(posedge clock); #1;
        total++;
        if (write_enable !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || written_count !== 9'd0) begin
            bad++;
            $display("FAIL abort_idle: got we=%b rdy=%b done=%b cnt=%0d, required 0 0 0 0",
                     write_enable, in_ready, done, written_count);
        end
        sb_q.delete();
        write_ready = 1'b1;
        @(posedge clock); #1;
        begin_run();
        stream(256, -1, 256, -1, 0, 2000);
        total++;
        if (sb_q.size() != 0 || wr != 256) begin
            bad++;
            $display("FAIL abort_rerun: got writes=%0d pending=%0d, required 256 0", wr, sb_q.size());
        end
        end_run();
    endtask

    task automatic test_reset_mid_run;
        begin_run();
        stream(256, -1, 10, -1, 0, 500);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || write_enable !== 1'b0 || write_bus !== 128'd0 || write_address !== 16'd0 ||
            done !== 1'b0 || written_count !== 9'd0 || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: got rdy=%b we=%b bus=%h addr=%h done=%b cnt=%0d err=%b, required all 0",
                     in_ready, write_enable, write_bus, write_address, done, written_count, addr_err);
        end
        sb_q.delete();
        in_valid = 1'b0;
        write_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        begin_run();
        stream(256, -1, 20, -1, 0, 500);
        end_run();
    endtask

`ifdef CDF_STORE_ADDR_CHECK_EN
    task automatic test_addr_check;
        begin_run();
        @(posedge clock); #1;
        in_valid   = 1'b1;
        in_data    = 20'h12345;
        in_address = 16'h0100;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (write_enable !== 1'b0 || addr_err !== 1'b1) begin
            bad++;
            $display("FAIL addr_check: got we=%b err=%b, required 0 1", write_enable, addr_err);
        end
        end_run();
        begin_run();
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL addr_err_clear: got %b, required 0", addr_err);
        end
        end_run();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        sent = 0;
        wr = 0;
        reset_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_address = '0;
        write_ready = 1'b1;
        test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_full_run();
        test_after_done();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
`ifdef CDF_STORE_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
